tlb_superpage: RTL and testbench

//  Next-generation TLB for the I/D caches: set-associative 4 KiB-page array plus a small fully

---
 rtl/tlb_superpage_pkg.sv | 19 +
 rtl/sram_1r1w.sv | 21 ++
 rtl/tlb_plru.sv | 45 ++++
 rtl/tlb_superpage.sv | 240 ++++++++++++++++++++++++
 tb/tb_tlb_superpage.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/tlb_superpage_pkg.sv
// Shared types for the superpage TLB: page index, ASID and the 4 KiB entry layout.
package tlb_superpage_pkg;
    localparam int PAGE_NUM_BITS = 20;
    localparam int ASID_WIDTH    = 8;

    typedef logic [PAGE_NUM_BITS-1:0] page_index_t;
    typedef logic [ASID_WIDTH-1:0]    asid_t;

    // "global" is a reserved word, so the field is is_global
    typedef struct packed {
        page_index_t vpage;
        asid_t       asid;
        page_index_t ppage;
        logic        present;
        logic        exe_writable;
        logic        supervisor;
        logic        is_global;
    } tlb_entry_t;
endpackage

// File: rtl/sram_1r1w.sv
// One-read one-write synchronous SRAM; a same-cycle write to the read address returns the new data.
module sram_1r1w #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end
endmodule

// File: rtl/tlb_plru.sv
// Per-set tree pseudo-LRU: heap-ordered node bits 1..NUM_WAYS-1, each bit points at the colder half.
module tlb_plru #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 16,
    localparam int WB = $clog2(NUM_WAYS),
    localparam int SB = $clog2(NUM_SETS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [SB-1:0] set_idx,
    input  logic          touch_en,
    input  logic [WB-1:0] touch_way,
    output logic [WB-1:0] victim_way
);
    logic [NUM_SETS-1:0][NUM_WAYS-1:1] tree;
    logic [NUM_WAYS-1:1] next_row;
    logic [WB-1:0] vnode, tnode;
    logic dir;

    always_comb begin
        vnode = WB'(1);
        victim_way = '0;
        for (int l = 0; l < WB; l++) begin
            victim_way[WB-1-l] = tree[set_idx][vnode];
            vnode = (vnode << 1) | WB'(tree[set_idx][vnode]);
        end
    end

    // Walk the accessed way's path, pointing every node away from it
    always_comb begin
        next_row = tree[set_idx];
        tnode = WB'(1);
        dir = 1'b0;
        for (int l = 0; l < WB; l++) begin
            dir = touch_way[WB-1-l];
            next_row[tnode] = ~dir;
            tnode = (tnode << 1) | WB'(dir);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tree <= '0;
        else if (touch_en) tree[set_idx] <= next_row;
    end
endmodule

// File: rtl/tlb_superpage.sv
// Two-stage TLB: set-associative 4 KiB array in SRAM plus fully associative superpage array in flops.
// Define TLB_PLRU_EN for per-set tree PLRU replacement; otherwise a global rotating pointer is used.
module tlb_superpage
    import tlb_superpage_pkg::*;
#(
    parameter int NUM_ENTRIES       = 64,
    parameter int NUM_WAYS          = 4,
    parameter int NUM_SUPER_ENTRIES = 4,
    parameter int SUPER_SHIFT       = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lookup_en,
    input  logic        update_en,
    input  logic        update_super,
    input  logic        invalidate_en,
    input  logic        invalidate_asid_en,
    input  logic        invalidate_all_en,
    input  page_index_t request_vpage_idx,
    input  asid_t       request_asid,
    input  page_index_t update_ppage_idx,
    input  logic        update_present,
    input  logic        update_exe_writable,
    input  logic        update_supervisor,
    input  logic        update_global,
    output page_index_t lookup_ppage_idx,
    output logic        lookup_hit,
    output logic        lookup_present,
    output logic        lookup_exe_writable,
    output logic        lookup_supervisor,
    output logic        lookup_super
);
    localparam int NUM_SETS = NUM_ENTRIES / NUM_WAYS;
    localparam int SET_BITS = $clog2(NUM_SETS);
    localparam int SUP_BITS = $clog2(NUM_SUPER_ENTRIES);
    localparam int TAG_BITS = PAGE_NUM_BITS - SUPER_SHIFT;
    typedef logic [TAG_BITS-1:0] super_tag_t;

    logic s2_lookup, s2_update, s2_super, s2_inval;
    page_index_t s2_vpage, s2_ppage;
    asid_t s2_asid;
    logic s2_present, s2_exe, s2_supv, s2_glob;
    logic [SET_BITS-1:0] s2_set;
    logic s1_any, wr4, wr_s;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid4, glob4;
    asid_t asid4 [NUM_SETS][NUM_WAYS];
    tlb_entry_t rd_entry [NUM_WAYS];
    tlb_entry_t wr_entry;
    logic [NUM_WAYS-1:0] hit4, first_inv4, policy4, tgt4;
    logic found4;

    logic [NUM_SUPER_ENTRIES-1:0] valid_s, glob_s, present_s, exe_s, supv_s;
    super_tag_t vtag_s [NUM_SUPER_ENTRIES];
    super_tag_t ptag_s [NUM_SUPER_ENTRIES];
    asid_t asid_s [NUM_SUPER_ENTRIES];
    logic [NUM_SUPER_ENTRIES-1:0] hit_s, victim_s, tgt_s;
    logic [SUP_BITS-1:0] rr_ptr;
    logic found_s;

    assign s1_any = lookup_en | update_en | invalidate_en;
    assign s2_set = s2_vpage[SET_BITS-1:0];
    assign wr4    = s2_update && !s2_super;
    assign wr_s   = s2_update && s2_super;
    assign wr_entry = '{vpage: s2_vpage, asid: s2_asid, ppage: s2_ppage, present: s2_present,
                        exe_writable: s2_exe, supervisor: s2_supv, is_global: s2_glob};

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        sram_1r1w #(.DEPTH(NUM_SETS), .WIDTH($bits(tlb_entry_t))) u_sram (
            .clk(clk), .re(s1_any), .raddr(request_vpage_idx[SET_BITS-1:0]), .rdata(rd_entry[w]),
            .we(wr4 && tgt4[w]), .waddr(s2_set), .wdata(wr_entry)
        );
    end

    always_comb begin
        hit4 = '0;
        first_inv4 = '0;
        found4 = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit4[w] = valid4[s2_set][w] && rd_entry[w].vpage == s2_vpage &&
                      (rd_entry[w].is_global || rd_entry[w].asid == s2_asid);
            if (!valid4[s2_set][w] && !found4) begin
                first_inv4[w] = 1'b1;
                found4 = 1'b1;
            end
        end
        tgt4 = (|hit4) ? hit4 : (found4 ? first_inv4 : policy4);
    end

    always_comb begin
        hit_s = '0;
        victim_s = '0;
        found_s = 1'b0;
        for (int e = 0; e < NUM_SUPER_ENTRIES; e++) begin
            hit_s[e] = valid_s[e] && vtag_s[e] == s2_vpage[PAGE_NUM_BITS-1:SUPER_SHIFT] &&
                       (glob_s[e] || asid_s[e] == s2_asid);
            if (!valid_s[e] && !found_s) begin
                victim_s[e] = 1'b1;
                found_s = 1'b1;
            end
        end
        if (!found_s) victim_s[rr_ptr] = 1'b1;
        tgt_s = (|hit_s) ? hit_s : victim_s;
    end

`ifdef TLB_PLRU_EN
    logic [$clog2(NUM_WAYS)-1:0] plru_victim, touch_way;
    logic touch_en;

    assign touch_en = (s2_lookup && |hit4) || wr4;
    always_comb begin
        touch_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (tgt4[w]) touch_way = $clog2(NUM_WAYS)'(w);
    end

    tlb_plru #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) u_plru (
        .clk(clk), .reset_n(reset_n), .set_idx(s2_set), .touch_en(touch_en),
        .touch_way(touch_way), .victim_way(plru_victim)
    );

    always_comb begin
        policy4 = '0;
        policy4[plru_victim] = 1'b1;
    end
`else
    logic [NUM_WAYS-1:0] rr4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rr4 <= NUM_WAYS'(1);
        else if (wr4 && !(|hit4)) rr4 <= {rr4[NUM_WAYS-2:0], rr4[NUM_WAYS-1]};
    end
    assign policy4 = rr4;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_lookup <= 1'b0;
            s2_update <= 1'b0;
            s2_super  <= 1'b0;
            s2_inval  <= 1'b0;
            valid4    <= '0;
            valid_s   <= '0;
            rr_ptr    <= '0;
        end else begin
            s2_lookup <= lookup_en;
            s2_update <= update_en;
            s2_super  <= update_en && update_super;
            s2_inval  <= invalidate_en;
            if (wr4) valid4[s2_set] <= valid4[s2_set] | tgt4;
            if (wr_s) begin
                valid_s <= valid_s | tgt_s;
                if (!(|hit_s)) rr_ptr <= rr_ptr + 1'b1;
            end
            if (s2_inval) begin
                valid4[s2_set] <= valid4[s2_set] & ~hit4;
                valid_s <= valid_s & ~hit_s;
            end
            if (invalidate_asid_en) begin
                for (int s = 0; s < NUM_SETS; s++)
                    for (int w = 0; w < NUM_WAYS; w++)
                        if (!glob4[s][w] && asid4[s][w] == request_asid) valid4[s][w] <= 1'b0;
                for (int e = 0; e < NUM_SUPER_ENTRIES; e++)
                    if (!glob_s[e] && asid_s[e] == request_asid) valid_s[e] <= 1'b0;
            end
            // Flush-all is last so it overrides any stage-2 insert on the same edge
            if (invalidate_all_en) begin
                valid4  <= '0;
                valid_s <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_any) begin
            s2_vpage   <= request_vpage_idx;
            s2_asid    <= request_asid;
            s2_ppage   <= update_ppage_idx;
            s2_present <= update_present;
            s2_exe     <= update_exe_writable;
            s2_supv    <= update_supervisor;
            s2_glob    <= update_global;
        end
        if (wr4)
            for (int w = 0; w < NUM_WAYS; w++)
                if (tgt4[w]) begin
                    asid4[s2_set][w] <= s2_asid;
                    glob4[s2_set][w] <= s2_glob;
                end
        if (wr_s)
            for (int e = 0; e < NUM_SUPER_ENTRIES; e++)
                if (tgt_s[e]) begin
                    vtag_s[e]    <= s2_vpage[PAGE_NUM_BITS-1:SUPER_SHIFT];
                    ptag_s[e]    <= s2_ppage[PAGE_NUM_BITS-1:SUPER_SHIFT];
                    asid_s[e]    <= s2_asid;
                    glob_s[e]    <= s2_glob;
                    present_s[e] <= s2_present;
                    exe_s[e]     <= s2_exe;
                    supv_s[e]    <= s2_supv;
                end
    end

    always_comb begin
        lookup_ppage_idx    = '0;
        lookup_hit          = 1'b0;
        lookup_present      = 1'b0;
        lookup_exe_writable = 1'b0;
        lookup_supervisor   = 1'b0;
        lookup_super        = 1'b0;
        if (s2_lookup) begin
            if (|hit_s) begin
                lookup_hit   = 1'b1;
                lookup_super = 1'b1;
                for (int e = 0; e < NUM_SUPER_ENTRIES; e++)
                    if (hit_s[e]) begin
                        lookup_ppage_idx    = {ptag_s[e], s2_vpage[SUPER_SHIFT-1:0]};
                        lookup_present      = present_s[e];
                        lookup_exe_writable = exe_s[e];
                        lookup_supervisor   = supv_s[e];
                    end
            end else if (|hit4) begin
                lookup_hit = 1'b1;
                for (int w = 0; w < NUM_WAYS; w++)
                    if (hit4[w]) begin
                        lookup_ppage_idx    = rd_entry[w].ppage;
                        lookup_present      = rd_entry[w].present;
                        lookup_exe_writable = rd_entry[w].exe_writable;
                        lookup_supervisor   = rd_entry[w].supervisor;
                    end
            end
        end
    end

    a_cmd_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({lookup_en, update_en, invalidate_en, invalidate_asid_en, invalidate_all_en}));
    a_way_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        (s2_lookup || s2_update || s2_inval) |-> $onehot0(hit4));
    a_no_dual_hit: assert property (@(posedge clk) disable iff (!reset_n)
        s2_lookup |-> !(|hit4 && |hit_s));
endmodule

// File: tb/tb_tlb_superpage.sv
// Directed bench for tlb_superpage; lookups push expectations, a negedge monitor pops and compares.
module tb_tlb_superpage;
    import tlb_superpage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic lookup_en = 0, update_en = 0, update_super = 0, invalidate_en = 0;
    logic invalidate_asid_en = 0, invalidate_all_en = 0;
    page_index_t request_vpage_idx = '0, update_ppage_idx = '0;
    asid_t request_asid = '0;
    logic update_present = 0, update_exe_writable = 0, update_supervisor = 0, update_global = 0;
    page_index_t lookup_ppage_idx;
    logic lookup_hit, lookup_present, lookup_exe_writable, lookup_supervisor, lookup_super;

    tlb_superpage dut (
        .clk(clk), .reset_n(reset_n), .lookup_en(lookup_en), .update_en(update_en),
        .update_super(update_super), .invalidate_en(invalidate_en),
        .invalidate_asid_en(invalidate_asid_en), .invalidate_all_en(invalidate_all_en),
        .request_vpage_idx(request_vpage_idx), .request_asid(request_asid),
        .update_ppage_idx(update_ppage_idx), .update_present(update_present),
        .update_exe_writable(update_exe_writable), .update_supervisor(update_supervisor),
        .update_global(update_global), .lookup_ppage_idx(lookup_ppage_idx),
        .lookup_hit(lookup_hit), .lookup_present(lookup_present),
        .lookup_exe_writable(lookup_exe_writable), .lookup_supervisor(lookup_supervisor),
        .lookup_super(lookup_super)
    );

    typedef struct {
        string       name;
        logic        hit;
        logic        sup;
        logic        pr, x, s;
        page_index_t ppage;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int n_checks = 0;
    int n_pass = 0;
    logic lk_d = 1'b0, cmd_d = 1'b0;
    logic [31:0] outs;

    assign outs = {lookup_hit, lookup_super, lookup_present, lookup_exe_writable,
                   lookup_supervisor, 7'd0, lookup_ppage_idx};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s got=%h want=%h", name, got, want);
        else n_pass++;
    endtask

    always @(posedge clk) begin
        lk_d  <= lookup_en;
        cmd_d <= lookup_en | update_en | invalidate_en | invalidate_asid_en | invalidate_all_en;
    end

    always @(negedge clk) begin
        if (reset_n && lk_d) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_response got=%h want=none", outs);
            end else begin
                e_mon = q.pop_front();
                if (e_mon.hit)
                    check(e_mon.name, outs, {1'b1, e_mon.sup, e_mon.pr, e_mon.x, e_mon.s, 7'd0, e_mon.ppage});
                else
                    check(e_mon.name, {31'd0, lookup_hit}, 32'd0);
            end
        end else if (reset_n && !cmd_d) begin
            check("idle_zero", outs, 32'd0);
        end
    end

    task automatic upd(input page_index_t v, input asid_t a, input page_index_t p, input logic sup,
                       input logic pr, input logic x, input logic s, input logic g);
        request_vpage_idx = v; request_asid = a; update_ppage_idx = p; update_super = sup;
        update_present = pr; update_exe_writable = x; update_supervisor = s; update_global = g;
        update_en = 1'b1;
        @(posedge clk); #1;
        update_en = 1'b0; update_super = 1'b0;
    endtask

    task automatic lkp(input string name, input page_index_t v, input asid_t a, input logic hit,
                       input page_index_t p, input logic sup, input logic pr, input logic x,
                       input logic s);
        exp_t e;
        e.name = name; e.hit = hit; e.ppage = p; e.sup = sup; e.pr = pr; e.x = x; e.s = s;
        q.push_back(e);
        request_vpage_idx = v; request_asid = a; lookup_en = 1'b1;
        @(posedge clk); #1;
        lookup_en = 1'b0;
    endtask

    task automatic miss(input string name, input page_index_t v, input asid_t a);
        lkp(name, v, a, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic inv(input page_index_t v, input asid_t a);
        request_vpage_idx = v; request_asid = a; invalidate_en = 1'b1;
        @(posedge clk); #1;
        invalidate_en = 1'b0;
    endtask

    task automatic inv_asid(input asid_t a);
        request_asid = a; invalidate_asid_en = 1'b1;
        @(posedge clk); #1;
        invalidate_asid_en = 1'b0;
    endtask

    task automatic inv_all();
        invalidate_all_en = 1'b1;
        @(posedge clk); #1;
        invalidate_all_en = 1'b0;
    endtask

    task automatic pulse_reset(input string name);
        reset_n = 1'b0;
        #1 check(name, outs, 32'd0);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_zero", outs, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 4 KiB translation, looked up the very next cycle (same-set bypass)
        upd(20'h12345, 8'd3, 20'h00abc, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        lkp("t1_hit", 20'h12345, 8'd3, 1'b1, 20'h00abc, 1'b0, 1'b1, 1'b1, 1'b0);
        miss("t1_asid_miss", 20'h12345, 8'd4);
        miss("t1_vpage_miss", 20'h12346, 8'd3);
        @(posedge clk); #1;

        // Superpage: low SUPER_SHIFT bits pass through from the virtual page
        upd(20'h00400, 8'd3, 20'h01000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        lkp("t2_super_top", 20'h007ff, 8'd3, 1'b1, 20'h013ff, 1'b1, 1'b1, 1'b0, 1'b1);
        lkp("t2_super_base", 20'h00400, 8'd3, 1'b1, 20'h01000, 1'b1, 1'b1, 1'b0, 1'b1);
        miss("t2_super_above", 20'h00800, 8'd3);

        // Per-ASID flush keeps global entries
        upd(20'h22226, 8'd3, 20'h00111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        upd(20'h33337, 8'd7, 20'h00222, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        lkp("t4_global_pre", 20'h33337, 8'd3, 1'b1, 20'h00222, 1'b0, 1'b1, 1'b1, 1'b1);
        inv_asid(8'd3);
        miss("t4_asid_gone", 20'h22226, 8'd3);
        miss("t4_old_gone", 20'h12345, 8'd3);
        miss("t4_super_gone", 20'h00500, 8'd3);
        lkp("t4_global_kept", 20'h33337, 8'd9, 1'b1, 20'h00222, 1'b0, 1'b1, 1'b1, 1'b1);

        // Single-entry invalidate
        upd(20'h4444a, 8'd1, 20'h00333, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        lkp("inv_pre", 20'h4444a, 8'd1, 1'b1, 20'h00333, 1'b0, 1'b0, 1'b1, 1'b0);
        inv(20'h4444a, 8'd1);
        miss("inv_post", 20'h4444a, 8'd1);

        inv_all();
        miss("t5_flush_all", 20'h33337, 8'd9);
        @(posedge clk); #1;

        // Five inserts into one set from a clean state: the first is evicted
        pulse_reset("t3_reset_zero");
        @(posedge clk); #1;
        for (int i = 1; i <= 5; i++)
            upd(page_index_t'(i * 16 + 10), 8'd2, page_index_t'(32'h100 + i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        miss("t3_evicted", 20'h0001a, 8'd2);
        lkp("t3_second_kept", 20'h0002a, 8'd2, 1'b1, 20'h00102, 1'b0, 1'b1, 1'b0, 1'b0);
        lkp("t3_fifth_in", 20'h0005a, 8'd2, 1'b1, 20'h00105, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Reset between an update and its stage 2 discards the update
        upd(20'h55555, 8'd1, 20'h00777, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        pulse_reset("t6_reset_zero");
        @(posedge clk); #1;
        miss("t6_discarded", 20'h55555, 8'd1);
        miss("t6_array_cleared", 20'h0002a, 8'd2);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL pending_responses got=%0d want=0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
